// File: rtl/normalize_pkg.sv
// Shared types and default geometry for the streaming z-score normalizer.
package normalize_pkg;

   typedef enum logic [1:0] {IDLE, SQRT, RECIP, STREAM} state_t;

   localparam int unsigned DEF_WIDTH      = 8;
   localparam int unsigned DEF_IMG_WIDTH  = 8;
   localparam int unsigned DEF_IMG_HEIGHT = 8;
   localparam int unsigned DEF_FRAC       = 8;

   localparam int unsigned INPUT_NUM = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
   localparam int unsigned OW        = DEF_WIDTH + DEF_FRAC + 1;
   localparam int unsigned CNT_W     = $clog2(INPUT_NUM + 1);

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/normalize_iter_divider.sv
// Restoring divider, one quotient bit per cycle after the start cycle.
module iter_divider
   import normalize_pkg::*;
#(
   parameter int unsigned DVD_W = 17,
   parameter int unsigned DVS_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] quotient
);

   localparam int unsigned CW = cnt_width(DVD_W);

   logic [DVD_W-1:0] r_dvd;
   logic [DVD_W-1:0] r_q;
   logic [DVS_W-1:0] r_dvs;
   logic [DVS_W-1:0] r_rem;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;

   logic [DVS_W:0]   w_rem_sh;
   logic             w_ge;
   logic [DVS_W-1:0] w_rem_nxt;

   always_comb begin
      w_rem_sh  = {r_rem, r_dvd[DVD_W-1]};
      w_ge      = (w_rem_sh >= {1'b0, r_dvs});
      w_rem_nxt = DVS_W'(w_ge ? (w_rem_sh - {1'b0, r_dvs}) : w_rem_sh);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dvd  <= '0;
         r_q    <= '0;
         r_dvs  <= '0;
         r_rem  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start && !r_busy) begin
            r_dvd  <= dividend;
            r_dvs  <= divisor;
            r_rem  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_dvd <= {r_dvd[DVD_W-2:0], 1'b0};
            r_rem <= w_rem_nxt;
            r_q   <= {r_q[DVD_W-2:0], w_ge};
            if (r_cnt == CW'(DVD_W - 1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign quotient = r_q;

endmodule

// File: rtl/normalize.sv
// Streaming z-score normalizer: per-frame sqrt and reciprocal, then (x-mean)*inv.
// NORMALIZE_ROUND_EN selects round-half-up instead of floor in the output stage.
module normalize
   import normalize_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int unsigned FRAC       = DEF_FRAC
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stats_valid,
   output logic                         stats_ready,
   input  logic [WIDTH-1:0]             mean,
   input  logic [2*WIDTH-1:0]           variance,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             data_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [WIDTH+FRAC:0]   data_out,
   output logic                         frame_done
);

   localparam int unsigned L_NUM  = IMG_WIDTH * IMG_HEIGHT;
   localparam int unsigned L_OW   = WIDTH + FRAC + 1;
   localparam int unsigned L_CW   = cnt_width(L_NUM);
   localparam int unsigned L_DW   = FRAC + WIDTH + 1;
   localparam int unsigned L_ITW  = cnt_width(FRAC + WIDTH);
   localparam int unsigned L_PW   = (WIDTH + 1) + (L_DW + 1);
   localparam logic [L_DW-1:0] L_ONE = {1'b1, {(FRAC+WIDTH){1'b0}}};
`ifdef NORMALIZE_ROUND_EN
   localparam logic signed [L_PW-1:0] L_ROUND = L_PW'(1 << (WIDTH - 1));
`else
   localparam logic signed [L_PW-1:0] L_ROUND = '0;
`endif

   state_t                   r_state;
   logic [WIDTH-1:0]         r_mean;
   logic [2*WIDTH-1:0]       r_rad;
   logic [WIDTH+1:0]         r_rem;
   logic [WIDTH-1:0]         r_root;
   logic [L_ITW-1:0]         r_cnt;
   logic [L_CW-1:0]          r_in_cnt;
   logic [L_CW-1:0]          r_out_cnt;
   logic [L_DW-1:0]          r_inv;
   logic                     r_s1_valid;
   logic signed [WIDTH:0]    r_diff;
   logic                     r_out_valid;
   logic signed [L_OW-1:0]   r_data_out;

   logic [WIDTH+3:0]         w_rem_sh;
   logic [WIDTH+3:0]         w_trial;
   logic                     w_sq_ge;
   logic [WIDTH+1:0]         w_rem_nxt;
   logic [WIDTH-1:0]         w_root_nxt;
   logic                     w_sqrt_last;
   logic                     w_div_busy;
   logic                     w_div_done;
   logic [L_DW-1:0]          w_quot;
   logic                     w_en;
   logic                     w_in_hs;
   logic                     w_out_hs;
   logic                     w_last;
   logic signed [L_PW-1:0]   w_prod;
   logic signed [L_OW-1:0]   w_shr;

   // Digit-by-digit square root: bring down two radicand bits, trial-subtract 4*root+1.
   always_comb begin
      w_rem_sh   = {r_rem, r_rad[2*WIDTH-1:2*WIDTH-2]};
      w_trial    = {2'b00, r_root, 2'b01};
      w_sq_ge    = (w_rem_sh >= w_trial);
      w_rem_nxt  = (WIDTH+2)'(w_sq_ge ? (w_rem_sh - w_trial) : w_rem_sh);
      w_root_nxt = {r_root[WIDTH-2:0], w_sq_ge};
   end

   assign w_sqrt_last = (r_state == SQRT) && (r_cnt == L_ITW'(WIDTH - 1));
   assign w_en        = !r_out_valid || out_ready;
   assign in_ready    = (r_state == STREAM) && (r_in_cnt < L_CW'(L_NUM)) && w_en;
   assign w_in_hs     = in_ready && in_valid;
   assign w_out_hs    = r_out_valid && out_ready;
   assign w_last      = w_out_hs && (r_out_cnt == L_CW'(L_NUM - 1));
   assign stats_ready = (r_state == IDLE) && !reset;
   assign out_valid   = r_out_valid;
   assign data_out    = r_data_out;
   assign frame_done  = w_last;

   // Divider is launched with the final root bit so its 17 iterations fill RECIP exactly.
   iter_divider #(
      .DVD_W (L_DW),
      .DVS_W (WIDTH)
   ) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (w_sqrt_last && !w_div_busy),
      .dividend (L_ONE),
      .divisor  (w_root_nxt),
      .busy     (w_div_busy),
      .done     (w_div_done),
      .quotient (w_quot)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_mean    <= '0;
         r_rad     <= '0;
         r_rem     <= '0;
         r_root    <= '0;
         r_cnt     <= '0;
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (stats_valid) begin
                  r_mean  <= mean;
                  r_rad   <= variance;
                  r_rem   <= '0;
                  r_root  <= '0;
                  r_cnt   <= '0;
                  r_state <= SQRT;
               end
            end
            SQRT: begin
               r_rad  <= {r_rad[2*WIDTH-3:0], 2'b00};
               r_rem  <= w_rem_nxt;
               r_root <= w_root_nxt;
               if (w_sqrt_last) begin
                  r_cnt   <= '0;
                  r_state <= RECIP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RECIP: begin
               if (r_cnt == L_ITW'(FRAC + WIDTH)) begin
                  r_cnt   <= '0;
                  r_state <= STREAM;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            STREAM: begin
               if (w_in_hs) r_in_cnt <= r_in_cnt + 1'b1;
               if (w_last) begin
                  r_in_cnt  <= '0;
                  r_out_cnt <= '0;
                  r_state   <= IDLE;
               end else if (w_out_hs) begin
                  r_out_cnt <= r_out_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      w_prod = L_PW'(r_diff) * L_PW'($signed({1'b0, r_inv}));
      w_shr  = L_OW'((w_prod + L_ROUND) >>> WIDTH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_inv       <= '0;
         r_s1_valid  <= 1'b0;
         r_diff      <= '0;
         r_out_valid <= 1'b0;
         r_data_out  <= '0;
      end else begin
         if (w_div_done) r_inv <= (r_root == '0) ? '0 : w_quot;
         if (w_en) begin
            r_s1_valid <= w_in_hs;
            if (w_in_hs) r_diff <= $signed((WIDTH+1)'(data_in) - (WIDTH+1)'(r_mean));
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) r_data_out <= w_shr;
         end
      end
   end

endmodule

// File: tb/tb_normalize.sv
// Randomized self-checking bench for normalize against an arithmetic z-score model.
module tb_normalize;

   localparam int W = 8;
   localparam int F = 8;
   localparam int N = 64;

   logic                clk = 1'b0;
   logic                reset;
   logic                stats_valid;
   logic                stats_ready;
   logic [W-1:0]        mean;
   logic [2*W-1:0]      variance;
   logic                in_valid;
   logic                in_ready;
   logic [W-1:0]        data_in;
   logic                out_valid;
   logic                out_ready;
   logic signed [W+F:0] data_out;
   logic                frame_done;

   int n_cmp = 0;
   int n_bad = 0;
   int pix[N];

   always #5 clk = ~clk;

   normalize #(.WIDTH(W), .IMG_WIDTH(8), .IMG_HEIGHT(8), .FRAC(F)) dut (
      .clk         (clk),
      .reset       (reset),
      .stats_valid (stats_valid),
      .stats_ready (stats_ready),
      .mean        (mean),
      .variance    (variance),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .data_in     (data_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .data_out    (data_out),
      .frame_done  (frame_done)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // z-score straight from the definition: floor sqrt, floor reciprocal, floor (or rounded) scale.
   function automatic longint model_out(input int x, input int m, input int v);
      int s = 0;
      longint inv, p, rnd;
      while ((s + 1) * (s + 1) <= v) s++;
      inv = (s == 0) ? 0 : ((longint'(1) << (F + W)) / s);
`ifdef NORMALIZE_ROUND_EN
      rnd = longint'(1) << (W - 1);
`else
      rnd = 0;
`endif
      p = longint'(x - m) * inv + rnd;
      return (p >= 0) ? (p / 256) : -((-p + 255) / 256);
   endfunction

   task automatic do_reset();
      reset = 1'b1; stats_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      data_in = '0; mean = '0; variance = '0;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_stats_ready", stats_ready, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_data_out", data_out, 0);
      check("rst_frame_done", frame_done, 0);
      reset = 1'b0;
      #1;
      check("idle_stats_ready", stats_ready, 1);
   endtask

   // mode 0: full rate, 1: random valid/ready, 2: 5-cycle stall + stray stats, 3: reset after 30 pixels
   task automatic run_frame(input int m, input int v, input int mode);
      longint exp_q[N];
      int n, it, idx, oidx, a, b, fd_cnt, stall_cnt;
      logic prev_stall;
      logic signed [W+F:0] prev_data;
      bit in_hs, out_hs, aborted;
      for (int i = 0; i < N; i++) exp_q[i] = model_out(pix[i], m, v);
      @(negedge clk);
      n = 0;
      while (!stats_ready && n < 100) begin @(negedge clk); n++; end
      stats_valid = 1'b1; mean = W'(m); variance = (2*W)'(v);
      #1;
      check("stats_ready", stats_ready, 1);
      n = 0;
      do begin
         @(negedge clk);
         stats_valid = 1'b0;
         #1;
         n++;
      end while (!in_ready && n < 200);
      check("in_ready_lat", n, 26);
      idx = 0; oidx = 0; it = 0; a = -1; b = -1; fd_cnt = 0; stall_cnt = 0;
      prev_stall = 1'b0; prev_data = '0; aborted = 1'b0;
      while (oidx < N && it < 2000 && !aborted) begin
         @(negedge clk);
         if (mode == 3 && idx == 30) begin
            aborted = 1'b1;
         end else begin
            it++;
            in_valid  = (idx < N) && ((mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
            data_in   = (idx < N) ? W'(pix[idx]) : '0;
            out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mode == 2 && oidx == 20 && stall_cnt < 5) begin
               out_ready = 1'b0;
               stall_cnt++;
            end
            if (mode == 2 && it == 10) begin
               stats_valid = 1'b1; mean = ~W'(m); variance = 16'h1234;
            end else begin
               stats_valid = 1'b0;
            end
            #1;
            if (stats_valid) check("stats_ignored", stats_ready, 0);
            if (prev_stall) check("hold_data", data_out, prev_data);
            in_hs  = in_valid && in_ready;
            out_hs = out_valid && out_ready;
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (in_hs && a < 0) a = it;
            if (out_valid && b < 0) b = it;
            check("frame_done", frame_done, out_hs && (oidx == N - 1));
            fd_cnt += int'(frame_done);
            if (out_hs) begin
               check($sformatf("pix%0d", oidx), data_out, exp_q[oidx]);
               oidx++;
            end
            if (in_hs) idx++;
            prev_stall = out_valid && !out_ready;
            prev_data  = data_out;
         end
      end
      in_valid = 1'b0; stats_valid = 1'b0; out_ready = 1'b1;
      if (aborted) begin
         do_reset();
      end else begin
         check("frame_timeout", oidx, N);
         check("latency", b - a, 2);
         check("frame_done_cnt", fd_cnt, 1);
         if (mode == 0) check("full_rate", it, 66);
         @(negedge clk);
         #1;
         check("b2b_ready", stats_ready, 1);
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) pix[i] = int'($urandom_range(0, 255));
   endtask

   initial begin
      do_reset();

      fill_random(); pix[0] = 120; pix[1] = 80;
      run_frame(100, 400, 0);

      for (int i = 0; i < N; i++) pix[i] = 50;
      run_frame(50, 0, 1);

      fill_random(); pix[0] = 255; pix[1] = 0;
      run_frame(0, 65025, 1);

      fill_random();
      run_frame(128, 2, 2);

      for (int k = 0; k < 3; k++) begin
         fill_random();
         run_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 65535)), 1);
      end

      fill_random();
      run_frame(int'($urandom_range(0, 255)), int'($urandom_range(1, 65535)), 3);

      fill_random(); pix[5] = 120; pix[6] = 80;
      run_frame(100, 400, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
